shared_bus_arbiter: RTL and testbench

//  Round-robin arbiter for one shared multi-driver (tri-state) 32-bit bus.

---
 rtl/bus_arb_pkg.sv | 43 ++++
 rtl/shared_bus_arbiter_rr_pick.sv | 31 +++
 rtl/shared_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_shared_bus_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the shared-bus arbiter.
//   arb_state_t : FSM encoding (IDLE=0, GRANT=1, TURN=2)
//   MAX_REQ     : widest requester vector supported by rr_pick
//   IDX_W       : width of requester indices (owner, round-robin pointer)
//   rr_pick     : round-robin one-hot pick of the first request at or after ptr
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // Rotate the request vector so ptr sits at bit 0, take the lowest set bit,
  // then rotate that single bit back into requester numbering.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr,
                                                 input int                 nreq);
    logic [MAX_REQ-1:0] rot;
    logic [MAX_REQ-1:0] onehot;
    logic [IDX_W-1:0]   pos;
    logic               found;
    rot    = '0;
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = IDX_W'((int'(ptr) + k) % nreq);
      if (k < nreq) rot[k] = req[pos];
    end
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = IDX_W'((int'(ptr) + k) % nreq);
      if (!found && rot[k]) begin
        onehot[pos] = 1'b1;
        found       = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// rr_priority_pick: combinational round-robin selector.
//   req    in  NREQ   request vector
//   ptr    in  IDX_W  highest-priority requester index
//   onehot out NREQ   selected requester (one-hot, zero when none)
//   idx    out IDX_W  binary index of the selected requester
//   any    out 1      at least one request pending
import bus_arb_pkg::*;

module rr_priority_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [MAX_REQ-1:0] pick_w;

  always_comb begin
    pick_w = rr_pick(MAX_REQ'(req), ptr, NREQ);
    onehot = pick_w[NREQ-1:0];
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_w[k]) idx = IDX_W'(k);
    end
    any = |pick_w;
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter: round-robin owner selection for a tri-state shared bus,
// with bounded hold time, an all-off turnaround gap between owners and an
// optional park driver that keeps the idle bus from floating.
//   clk     in  1     rising-edge clock
//   rst     in  1     synchronous active-high reset
//   req     in  NREQ  level requests
//   last    in  NREQ  owner's final beat (only the owner's bit is used)
//   gnt     out NREQ  one-hot grant
//   oe      out NREQ  driver enables (identical to gnt)
//   park_oe out 1     park driver enable
//   owner   out 3     current holder index (meaningful while busy)
//   busy    out 1     a grant is active
//   preempt out 1     one-cycle pulse after a hold-time expiry
import bus_arb_pkg::*;

module shared_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAXHOLD  = 8,
  parameter int TURN_CYC = 1,
  parameter int PARK     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  last,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  oe,
  output logic             park_oe,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             preempt
);

  localparam int BW = $clog2(MAXHOLD) + 1;
  localparam int TW = $clog2(TURN_CYC) + 1;
  localparam logic [BW-1:0] HOLD_LAST = BW'(MAXHOLD - 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYC - 1);
  localparam logic          PARK_EN   = (PARK != 0);

  arb_state_t       state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [TW-1:0]    turn_q, turn_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             park_q, park_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             preempt_q, preempt_d;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic own_last, own_req, expire, arb_now;

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    turn_d    = turn_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    park_d    = park_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;

    // Masking with the grant ignores last/req from anyone but the owner.
    own_last = |(last & gnt_q);
    own_req  = |(req & gnt_q);
    expire   = (beat_q == HOLD_LAST);
    arb_now  = (state_q == IDLE) || ((state_q == TURN) && (turn_q == '0));

    case (state_q)
      GRANT: begin
        if (own_last || !own_req || expire) begin
          state_d   = TURN;
          gnt_d     = '0;
          busy_d    = 1'b0;
          park_d    = 1'b0;
          turn_d    = TURN_LOAD;
          ptr_d     = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          // Expiry only counts as preemption when the owner still wanted the bus.
          preempt_d = expire && !own_last && own_req;
        end else if (beat_q != '1) begin
          beat_d = beat_q + 1'b1;
        end
      end
      TURN: begin
        if (turn_q != '0) turn_d = turn_q - 1'b1;
      end
      default: ;
    endcase

    // Final turnaround cycle arbitrates exactly like IDLE.
    if (arb_now) begin
      if (pick_any) begin
        state_d = GRANT;
        gnt_d   = pick_onehot;
        owner_d = pick_idx;
        busy_d  = 1'b1;
        park_d  = 1'b0;
        beat_d  = '0;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        park_d  = PARK_EN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      turn_q    <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      park_q    <= PARK_EN;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      turn_q    <= turn_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      park_q    <= park_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign oe      = gnt_q;
  assign park_oe = park_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Testbench for shared_bus_arbiter: directed vector table, hand-written
// round-robin and hold-expiry sequences, then randomized traffic on a
// tri-state bus checked against an abstract reference model.
module tb_shared_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int MAXHOLD  = 8;
  localparam int TURN_CYC = 1;
  localparam int PARK     = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] last = '0;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] oe;
  logic            park_oe;
  logic [2:0]      owner;
  logic            busy;
  logic            preempt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shared_bus_arbiter #(
    .NREQ(NREQ), .MAXHOLD(MAXHOLD), .TURN_CYC(TURN_CYC), .PARK(PARK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .last    (last),
    .gnt     (gnt),
    .oe      (oe),
    .park_oe (park_oe),
    .owner   (owner),
    .busy    (busy),
    .preempt (preempt)
  );

  // Shared tri-state bus: each requester drives {a[7:2], b, c[9:3], fill}.
  logic [31:0] drv_word [NREQ];
  wire  [31:0] bus;
  assign bus = oe[0]   ? drv_word[0] : 32'bz;
  assign bus = oe[1]   ? drv_word[1] : 32'bz;
  assign bus = oe[2]   ? drv_word[2] : 32'bz;
  assign bus = oe[3]   ? drv_word[3] : 32'bz;
  assign bus = park_oe ? 32'h0       : 32'bz;

  // Reference model: who holds the bus, for how many beats, and how many
  // blackout cycles remain before the next arbitration.
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_ptr   = 0;
  bit m_pre   = 1'b0;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (p + k) % NREQ;
      if (r[i[1:0]]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [NREQ-1:0] q, input logic [NREQ-1:0] l);
    logic ol, oq;
    m_pre = 1'b0;
    if (r) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      ol = l[m_owner[1:0]];
      oq = q[m_owner[1:0]];
      if (ol || !oq || m_held == MAXHOLD) begin
        m_pre   = (m_held == MAXHOLD) && !ol && oq;
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_gap   = TURN_CYC;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap   = 0;
      m_owner = pick(q, m_ptr);
      m_held  = 0;
    end
  endtask

  function automatic logic [NREQ-1:0] m_gnt();
    return (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
  endfunction

  function automatic logic m_park();
    return (PARK != 0) && (m_owner < 0) && (m_gap == 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, let the DUT and model
  // advance on the rising edge, and return 1 time unit later for sampling.
  task automatic step(input logic r, input logic [NREQ-1:0] q, input logic [NREQ-1:0] l);
    logic [7:0]  fa;
    logic        fb;
    logic [9:0]  fc;
    logic [17:0] ff;
    @(negedge clk);
    rst  = r;
    req  = q;
    last = l;
    for (int k = 0; k < NREQ; k++) begin
      fa = 8'($urandom);
      fb = 1'($urandom);
      fc = 10'($urandom);
      ff = 18'($urandom);
      drv_word[k] = {fa[7:2], fb, fc[9:3], ff};
    end
    @(posedge clk);
    model_step(r, q, l);
    #1;
  endtask

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] last;
    logic [NREQ-1:0] gnt;
    logic            park;
    logic            busy;
    logic            pre;
    logic [2:0]      own;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] l,
                              input logic [3:0] g, input logic p, input logic b,
                              input logic pr, input logic [2:0] o);
    vec_t v;
    v = '{r, q, l, g, p, b, pr, o};
    tbl.push_back(v);
  endfunction

  initial begin
    int pre_cnt;
    logic [NREQ-1:0] rq;
    logic [NREQ-1:0] exp_g;
    logic            rr;
    logic [NREQ-1:0] rl;

    for (int k = 0; k < NREQ; k++) drv_word[k] = '0;

    // rst req  last  -> gnt  park busy pre owner
    add(1, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);   // reset
    for (int k = 0; k < 5; k++)
      add(0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0); // idle, parked
    add(0, 4'h1, 4'h0, 4'h1, 0, 1, 0, 0);   // grant 0 one clock after req
    add(0, 4'h1, 4'h0, 4'h1, 0, 1, 0, 0);
    add(0, 4'h1, 4'h0, 4'h1, 0, 1, 0, 0);
    add(0, 4'h1, 4'h1, 4'h0, 0, 0, 0, 0);   // last on 3rd beat -> turnaround
    add(0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);   // then park
    add(0, 4'h4, 4'h0, 4'h4, 0, 1, 0, 2);   // rr_ptr=1 -> owner 2
    add(1, 4'h4, 4'h0, 4'h0, 1, 0, 0, 0);   // reset mid-grant
    add(0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
    add(0, 4'h4, 4'h0, 4'h4, 0, 1, 0, 2);   // owner 2
    add(0, 4'hD, 4'h0, 4'h4, 0, 1, 0, 2);   // others ignored while 2 holds
    add(0, 4'h9, 4'h0, 4'h0, 0, 0, 0, 0);   // 2 abandons at beat 1
    add(0, 4'h9, 4'h0, 4'h8, 0, 1, 0, 3);   // rr_ptr=3 -> owner 3, not 0
    add(0, 4'h9, 4'h8, 4'h0, 0, 0, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].last);
      check($sformatf("vec%0d", i), {gnt, oe, park_oe, busy, preempt},
            {tbl[i].gnt, tbl[i].gnt, tbl[i].park, tbl[i].busy, tbl[i].pre});
      if (tbl[i].busy) check($sformatf("vec%0d_owner", i), owner, tbl[i].own);
    end

    // All four requesting, last on every 2nd beat: owners 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      exp_g = NREQ'(1 << (k % NREQ));
      step(0, 4'hF, 4'h0);
      check($sformatf("rr%0d_beat0", k), {gnt, park_oe, busy}, {exp_g, 1'b0, 1'b1});
      check($sformatf("rr%0d_owner", k), owner, 3'(k % NREQ));
      step(0, 4'hF, 4'h0);
      check($sformatf("rr%0d_beat1", k), {gnt, park_oe, busy}, {exp_g, 1'b0, 1'b1});
      step(0, 4'hF, 4'hF);
      check($sformatf("rr%0d_gap", k), {gnt, park_oe, busy}, {4'h0, 1'b0, 1'b0});
    end

    // Requester 1 alone, never says last: 8 beats, preempt pulse, 1 gap, regrant.
    pre_cnt = 0;
    for (int c = 0; c < 18; c++) begin
      step(0, 4'h2, 4'h0);
      if (preempt) pre_cnt++;
      check($sformatf("hold%0d", c), {gnt, park_oe, preempt},
            {((c % 9) != 8) ? 4'h2 : 4'h0, 1'b0, ((c % 9) == 8) ? 1'b1 : 1'b0});
    end
    check("preempt_count", pre_cnt, 2);
    step(0, 4'h0, 4'h0);
    step(0, 4'h0, 4'h0);
    check("hold_end_park", {gnt, park_oe}, {4'h0, 1'b1});

    // Randomized traffic against the reference model.
    rq = '0;
    for (int c = 0; c < 10000; c++) begin
      rr = ($urandom_range(0, 999) == 0);
      rq = rq ^ NREQ'($urandom & $urandom & $urandom);
      rl = NREQ'($urandom & $urandom & $urandom);
      step(rr, rq, rl);
      check("rand_ctrl", {gnt, oe, park_oe, busy, preempt},
            {m_gnt(), m_gnt(), m_park(), (m_owner >= 0), m_pre});
      if (m_owner >= 0) begin
        check("rand_owner", owner, 3'(m_owner));
        check("rand_bus_field", bus, drv_word[m_owner[1:0]]);
      end else if (m_park()) begin
        check("rand_bus_park", bus, 32'h0);
      end
      if (oe != '0 || park_oe) check("rand_bus_x", $isunknown(bus), 0);
      check("one_driver", (($countones(oe) + int'(park_oe)) <= 1), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
